hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage core: generates operand-forwarding selects for the execute stage, load-use stalls, branch/jump flushes and data-memory wait freezes. It sits beside the pipeline registers and drives their stall (hold) and clear (bubble) controls. It also supervises data-memory handshakes with a timeout FSM and keeps a saturating stall-cycle counter for performance analysis.

## Interface
- MEM_TIMEOUT, default 64: number of consecutive wait cycles (`mem_req & ~mem_ack`) before the fault is declared; legal range 2..65535.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in execute.
- ex_rd  in  5  destination of the instruction in execute.
- ex_result_src  in  2  result select of the execute instruction; 2'b01 = load.
- ex_pc_src  in  1  branch/jump taken, from the execute stage.
- mem_rd, mem_reg_write  in  5 / 1  destination and write-enable of the instruction in the MEM stage.
- wb_rd, wb_reg_write  in  5 / 1  destination and write-enable of the instruction in the WB stage.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ack  in  1  data memory completes the access this cycle.
- ex_op1_forward, ex_op2_forward  out  2 each  00 = register file, 01 = WB result, 10 = MEM ALU result.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- id_clear, ex_clear, wb_clear  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB on the next edge.
- mem_fault  out  1  sticky data-memory timeout flag.
- stall_count  out  32  saturating count of cycles with if_stall = 1.

## Operation
- Forwarding (combinational), per operand: MEM match (`mem_reg_write`, mem_rd ≠ 0, mem_rd = ex_rsN) → 10; else WB match under the same rule → 01; else 00. MEM has priority over WB. Register x0 never forwards.
- Load-use hazard (lu): `ex_result_src == 2'b01` and ex_rd ≠ 0 and ex_rd equals id_rs1 or id_rs2. Response:
  - if_stall = 1 and id_stall = 1.
  - ex_clear = 1.
  - Exactly one bubble is inserted.
- Flush (fl): `ex_pc_src` = 1 → id_clear = 1 and ex_clear = 1. If fl and lu occur together, fl wins and if_stall/id_stall stay 0.
- Memory wait (mw): `mem_req & ~mem_ack`. Response:
  - if_stall = id_stall = ex_stall = mem_stall = 1.
  - wb_clear = 1.
  - id_clear and ex_clear are forced to 0.
  - mw overrides fl and lu. Because EX is frozen, ex_pc_src stays asserted, so the flush takes effect in the first cycle after release.
- FSM states: RUN, WAIT, FAULT. A 16-bit wait counter wcnt is used.
  - RUN: if mw → WAIT, wcnt ← 1.
  - WAIT:
    - if mem_ack → RUN, wcnt ← 0.
    - else if wcnt = MEM_TIMEOUT−1 → FAULT.
    - else wcnt ← wcnt+1.
  - FAULT: mem_fault = 1, and all four stalls plus wb_clear are held at 1 regardless of inputs, until reset.
- stall_count increments by 1 each cycle if_stall = 1; it holds at 32'hFFFF_FFFF.
- Reset cycle (reset = 1):
  - FSM ← RUN, wcnt ← 0, mem_fault ← 0, stall_count ← 0.
  - Combinational outputs are forced: forwards = 00, all stalls = 0, id_clear = ex_clear = wb_clear = 1.

## Timing
- Forward selects, stalls and clears are combinational from the current-cycle inputs and FSM state. Pipeline registers act on them at the next rising edge. No added latency.
- Load-use costs exactly 1 cycle. A taken branch costs 2 cycles (two bubbles).
- Memory wait:
  - The stall is asserted in every cycle with mem_req=1 and mem_ack=0.
  - In the cycle mem_ack=1, stalls are 0, so the pipeline advances on that edge.
  - A zero-wait access (mem_req & mem_ack in the same cycle) never leaves RUN.
- Timeout: mem_fault rises after the edge ending the MEM_TIMEOUT-th consecutive wait cycle. An ack in that last cycle takes priority and returns the FSM to RUN without a fault.
- reset asserted mid-WAIT or in FAULT returns the block to RUN on that edge. Stalls are 0 during the reset cycle.
- stall_count is registered: it reflects stalls up to and including the previous cycle.

## Test plan
- Forwarding priority: ex_rs1 = 5, mem_rd = 5/mem_reg_write = 1, wb_rd = 5/wb_reg_write = 1 → ex_op1_forward = 10. Repeat with mem_reg_write = 0 → 01. Repeat with all rd = 0 → 00.
- Load-use: ex_result_src = 01, ex_rd = 3, id_rs2 = 3 → if_stall = id_stall = ex_clear = 1 for one cycle; stall_count goes 0→1.
- Branch + load-use together: ex_pc_src = 1 with the load-use condition above → id_clear = ex_clear = 1, if_stall = 0.
- Memory wait: mem_req = 1, mem_ack low 3 cycles then high → all stalls and wb_clear = 1 for 3 cycles, 0 on the ack cycle; FSM back in RUN; stall_count = 3.
- Timeout: MEM_TIMEOUT = 4, mem_req = 1, mem_ack = 0 held → mem_fault = 1 after the 4th wait edge and stays 1. Then reset = 1 for one cycle → mem_fault = 0, stall_count = 0, forwards = 00.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch flushes,
// data-memory wait freezes with a timeout FSM, and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_result_src,
  input  logic        ex_pc_src,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  ex_op1_forward,
  output logic [1:0]  ex_op2_forward,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        id_clear,
  output logic        ex_clear,
  output logic        wb_clear,
  output logic        mem_fault,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic mw, lu, fl;

  assign mw = mem_req & ~mem_ack;
  assign lu = (ex_result_src == 2'b01) && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign fl = ex_pc_src;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b10;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Priority: reset > fault freeze > memory wait > flush > load-use
  always_comb begin
    ex_op1_forward = fwd_sel(ex_rs1);
    ex_op2_forward = fwd_sel(ex_rs2);
    if_stall       = 1'b0;
    id_stall       = 1'b0;
    ex_stall       = 1'b0;
    mem_stall      = 1'b0;
    id_clear       = 1'b0;
    ex_clear       = 1'b0;
    wb_clear       = 1'b0;
    if (reset) begin
      ex_op1_forward = 2'b00;
      ex_op2_forward = 2'b00;
      id_clear       = 1'b1;
      ex_clear       = 1'b1;
      wb_clear       = 1'b1;
    end else if ((state_q == FAULT) || mw) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      wb_clear  = 1'b1;
    end else if (fl) begin
      id_clear = 1'b1;
      ex_clear = 1'b1;
    end else if (lu) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_clear = 1'b1;
    end
  end

  // An ack in the final allowed wait cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          state_d = WAIT;
          wcnt_d  = 16'd1;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = FAULT;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      FAULT: state_d = FAULT;
      default: begin
        state_d = RUN;
        wcnt_d  = 16'd0;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (if_stall && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wcnt_q        <= 16'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_fault   = (state_q == FAULT);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller with a short memory timeout.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]  ex_result_src;
  logic        ex_pc_src, mem_reg_write, wb_reg_write, mem_req, mem_ack;
  logic [1:0]  ex_op1_forward, ex_op2_forward;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        id_clear, ex_clear, wb_clear, mem_fault;
  logic [31:0] stall_count;

  int testCount = 0;
  int failCount = 0;

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .ex_op1_forward(ex_op1_forward), .ex_op2_forward(ex_op2_forward),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .id_clear(id_clear), .ex_clear(ex_clear), .wb_clear(wb_clear),
    .mem_fault(mem_fault), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic [4:0] i_id_rs1, input logic [4:0] i_id_rs2,
    input logic [4:0] i_ex_rs1, input logic [4:0] i_ex_rs2,
    input logic [4:0] i_ex_rd,  input logic [1:0] i_ex_result_src,
    input logic i_ex_pc_src,
    input logic [4:0] i_mem_rd, input logic i_mem_reg_write,
    input logic [4:0] i_wb_rd,  input logic i_wb_reg_write,
    input logic i_mem_req, input logic i_mem_ack);
    id_rs1 = i_id_rs1; id_rs2 = i_id_rs2; ex_rs1 = i_ex_rs1; ex_rs2 = i_ex_rs2;
    ex_rd = i_ex_rd; ex_result_src = i_ex_result_src; ex_pc_src = i_ex_pc_src;
    mem_rd = i_mem_rd; mem_reg_write = i_mem_reg_write;
    wb_rd = i_wb_rd; wb_reg_write = i_wb_reg_write;
    mem_req = i_mem_req; mem_ack = i_mem_ack;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  // Checks the whole stall/clear vector packed as {if,id,ex,mem,idc,exc,wbc}
  task automatic checkControls(input string tag, input logic [6:0] expected);
    checkOutput(tag, {25'd0, if_stall, id_stall, ex_stall, mem_stall, id_clear, ex_clear, wb_clear},
                {25'd0, expected});
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0,0,5,0,0,2'b00,0, 5,1, 5,1, 0,0);
    checkOutput("reset_fwd1", ex_op1_forward, 2'b00);
    checkControls("reset_ctrl", 7'b0000_111);
    clockEdge();
    reset = 1'b0;
    applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 0,0);
    checkOutput("reset_count", stall_count, 0);
    checkOutput("reset_fault", mem_fault, 0);
    checkControls("idle_ctrl", 7'b0000_000);

    applyStimulus(0,0,5,0,0,2'b00,0, 5,1, 5,1, 0,0);
    checkOutput("fwd_mem_prio", ex_op1_forward, 2'b10);
    applyStimulus(0,0,5,0,0,2'b00,0, 5,0, 5,1, 0,0);
    checkOutput("fwd_wb", ex_op1_forward, 2'b01);
    applyStimulus(0,0,5,0,0,2'b00,0, 0,1, 0,1, 0,0);
    checkOutput("fwd_x0", ex_op1_forward, 2'b00);
    applyStimulus(0,0,0,7,0,2'b00,0, 5,1, 7,1, 0,0);
    checkOutput("fwd_op2_wb", ex_op2_forward, 2'b01);
    checkOutput("fwd_op1_none", ex_op1_forward, 2'b00);
    applyStimulus(0,0,0,0,0,2'b00,0, 0,1, 0,1, 0,0);
    checkOutput("fwd_op2_x0", ex_op2_forward, 2'b00);

    applyStimulus(0,3,0,0,3,2'b01,0, 0,0, 0,0, 0,0);
    checkControls("lu_ctrl", 7'b1100_010);
    clockEdge();
    applyStimulus(0,3,0,0,0,2'b00,0, 0,0, 0,0, 0,0);
    checkControls("lu_bubble_done", 7'b0000_000);
    checkOutput("lu_count", stall_count, 1);

    applyStimulus(0,0,0,0,0,2'b01,0, 0,0, 0,0, 0,0);
    checkControls("lu_x0", 7'b0000_000);
    applyStimulus(0,3,0,0,3,2'b01,1, 0,0, 0,0, 0,0);
    checkControls("flush_beats_lu", 7'b0000_110);
    clockEdge();
    checkOutput("flush_count", stall_count, 1);

    reset = 1'b1;
    applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 0,0);
    clockEdge();
    reset = 1'b0;
    checkOutput("reset2_count", stall_count, 0);

    // Memory wait with a pending flush; the flush must appear on the ack cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0,0,0,2'b00,1, 0,0, 0,0, 1,0);
      checkControls($sformatf("mw_ctrl%0d", i), 7'b1111_001);
      clockEdge();
    end
    applyStimulus(0,0,0,0,0,2'b00,1, 0,0, 0,0, 1,1);
    checkControls("mw_ack_ctrl", 7'b0000_110);
    clockEdge();
    checkOutput("mw_count", stall_count, 3);
    checkOutput("mw_no_fault", mem_fault, 0);

    applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 1,1);
    checkControls("zero_wait_ctrl", 7'b0000_000);
    clockEdge();
    checkOutput("zero_wait_count", stall_count, 3);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 1,0);
      checkOutput($sformatf("to_prefault%0d", i), mem_fault, 0);
      clockEdge();
    end
    checkOutput("to_fault", mem_fault, 1);
    checkOutput("to_count", stall_count, 7);
    applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 0,0);
    checkControls("fault_hold_ctrl", 7'b1111_001);
    clockEdge();
    checkOutput("fault_sticky", mem_fault, 1);
    checkOutput("fault_count", stall_count, 8);

    reset = 1'b1;
    applyStimulus(0,0,5,5,0,2'b00,0, 5,1, 5,1, 1,0);
    checkControls("fault_reset_ctrl", 7'b0000_111);
    checkOutput("fault_reset_fwd", {ex_op1_forward, ex_op2_forward}, 4'b0000);
    clockEdge();
    reset = 1'b0;
    applyStimulus(0,0,0,0,0,2'b00,0, 0,0, 0,0, 0,0);
    checkOutput("post_reset_fault", mem_fault, 0);
    checkOutput("post_reset_count", stall_count, 0);
    checkControls("post_reset_ctrl", 7'b0000_000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
